// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared definitions for the SPI responder.
//   W_SPI      default word width (matches the CPU word width)
//   state_t    responder frame state (idle / active)
//   SPI_CPOL,
//   SPI_CPHA   bus mode constants, also used by the controller side
package spi_slave_pkg;

  localparam int unsigned W_SPI = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_slave_sync.sv
// spi_sync: two-flop synchronizer for an asynchronous pin plus a third
// flop for edge detection.
//   clk, rst  system clock, asynchronous active-high reset
//   pin       asynchronous input
//   level     synchronized level (second flop)
//   rise      one-cycle strobe on a synchronized 0->1 transition
//   fall      one-cycle strobe on a synchronized 1->0 transition
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI responder, mode 0, MSB first, oversampled in the clk domain.
//   clk, rst     system clock (>= 8x SCLK), asynchronous active-high reset
//   sclk, cs_n,
//   mosi         SPI pins from the controller (asynchronous)
//   miso         responder data out, 0 outside a frame
//   miso_oe      MISO drive enable, high while the frame is active
//   tx_data,
//   tx_valid,
//   tx_ready     one-entry TX holding register with valid/ready handshake
//   rx_data      last complete received word
//   rx_valid     one-cycle strobe: rx_data updated
//   tx_underrun  one-cycle strobe: word started with an empty holding register
//   frame_abort  one-cycle strobe: cs_n released mid-word
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned W = W_SPI
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  output logic         tx_underrun,
  output logic         frame_abort
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_lvl_unused, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .pin   (sclk),
    .level (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .pin   (cs_n),
    .level (cs_lvl_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .pin   (mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [W-2:0]  rx_shift;   // top bit never needed: full word goes straight to rx_data
  logic [W-1:0]  tx_shift;
  logic [W-1:0]  hold;       // valid when tx_ready is low

  logic          sample_edge, shift_edge;
  logic          word_load;
  logic          handshake;
  logic [W-1:0]  load_word;
  logic [W-1:0]  rx_word;

  always_comb begin
    sample_edge = (SPI_CPOL ^ SPI_CPHA) ? sclk_fall : sclk_rise;
    shift_edge  = (SPI_CPOL ^ SPI_CPHA) ? sclk_rise : sclk_fall;
    handshake   = tx_valid & tx_ready;
    // A new word enters tx_shift at frame start and on the shift edge that
    // follows a completed word; cs_n release takes priority over that edge.
    word_load   = ((state == ST_IDLE) && cs_fall) ||
                  ((state == ST_ACTIVE) && !cs_rise && shift_edge && (bit_cnt == '0));
    load_word   = tx_ready ? '0 : hold;
    rx_word     = {rx_shift, mosi_s};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      tx_ready    <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;

      // Handshake and word load in the same cycle: load_word already holds
      // the old content (or zeros), and the new word stays in hold.
      if (handshake) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end else if (word_load) begin
        tx_ready <= 1'b1;
      end

      if (word_load) begin
        tx_shift    <= load_word;
        miso        <= load_word[W-1];
        tx_underrun <= tx_ready;
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_ACTIVE;
            bit_cnt <= '0;
            miso_oe <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            // Partial word is dropped; tx_shift content counts as consumed.
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            frame_abort <= (bit_cnt != '0);
          end else if (sample_edge) begin
            rx_shift <= rx_word[W-2:0];
            if (bit_cnt == LAST_BIT) begin
              rx_data  <= rx_word;
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (shift_edge && (bit_cnt != '0)) begin
            tx_shift <= tx_shift << 1;
            miso     <= tx_shift[W-2];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as an SPI controller
// (mode 0, SCLK = clk/8) with a vector table plus hand-written sequences.
module tb_spi_slave;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         sclk;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         tx_underrun;
  logic         frame_abort;

  spi_slave #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Pulse counters, sampled away from the active edge.
  int rx_cnt = 0;
  int ur_cnt = 0;
  int ab_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid)    rx_cnt++;
    if (tx_underrun) ur_cnt++;
    if (frame_abort) ab_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [W-1:0] word);
    bit done = 0;
    tx_data  = word;
    tx_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (tx_ready) done = 1;
      tick(1);
    end
    tx_valid = 1'b0;
    if (!done) check("tx_ready_wait", 64'd0, 64'd1);
    else       check("tx_ready_drop", {63'd0, tx_ready}, 64'd0);
  endtask

  // Shift nbits MSB-first; optionally release cs_n together with the last fall.
  task automatic shift_bits(input logic [W-1:0] word, input int nbits,
                            input bit end_frame, output logic [W-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[W-1-i];
      tick(4);
      got  = {got[W-2:0], miso};
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      if (end_frame && i == nbits - 1) cs_n = 1'b1;
    end
    mosi = 1'b0;
  endtask

  task automatic frame(input logic [W-1:0] word, output logic [W-1:0] got);
    cs_n = 1'b0;
    shift_bits(word, W, 1'b1, got);
    tick(8);
  endtask

  typedef struct {
    bit           preload;
    logic [W-1:0] tx_word;
    logic [W-1:0] mosi_word;
    logic [W-1:0] exp_miso;
    int           exp_underrun;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [W-1:0] got, got2;
    int r0, u0, a0;

    vecs[0] = '{1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 32'hA5A5_0F0F, 0};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[2] = '{1'b1, 32'h7FFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFE, 0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0};

    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    tick(3);
    check("reset_outputs",
          {26'd0, miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort},
          {26'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    tick(4);
    check("post_reset_idle", {62'd0, miso_oe, tx_ready}, {62'd0, 1'b0, 1'b1});

    // Table-driven single-word frames.
    for (int v = 0; v < 4; v++) begin
      r0 = rx_cnt; u0 = ur_cnt; a0 = ab_cnt;
      if (vecs[v].preload) push_tx(vecs[v].tx_word);
      frame(vecs[v].mosi_word, got);
      check($sformatf("v%0d_rx_data", v), {32'd0, rx_data}, {32'd0, vecs[v].mosi_word});
      check($sformatf("v%0d_rx_pulses", v), 64'(rx_cnt - r0), 64'd1);
      check($sformatf("v%0d_miso_word", v), {32'd0, got}, {32'd0, vecs[v].exp_miso});
      check($sformatf("v%0d_underrun", v), 64'(ur_cnt - u0), 64'(vecs[v].exp_underrun));
      check($sformatf("v%0d_abort", v), 64'(ab_cnt - a0), 64'd0);
      check($sformatf("v%0d_tx_ready", v), {63'd0, tx_ready}, 64'd1);
      check($sformatf("v%0d_miso_oe_off", v), {63'd0, miso_oe}, 64'd0);
    end

    // Back-to-back words in one frame, holding register refilled mid-frame.
    r0 = rx_cnt; u0 = ur_cnt;
    push_tx(32'hCAFE_F00D);
    cs_n = 1'b0;
    tick(6);
    check("b2b_miso_oe_on", {63'd0, miso_oe}, 64'd1);
    push_tx(32'h1357_9BDF);
    shift_bits(32'hDEAD_BEEF, W, 1'b0, got);
    check("b2b_rx1", {32'd0, rx_data}, {32'd0, 32'hDEAD_BEEF});
    check("b2b_rx1_pulses", 64'(rx_cnt - r0), 64'd1);
    shift_bits(32'h0000_0001, W, 1'b1, got2);
    tick(8);
    check("b2b_rx2", {32'd0, rx_data}, {32'd0, 32'h0000_0001});
    check("b2b_rx_pulses", 64'(rx_cnt - r0), 64'd2);
    check("b2b_miso1", {32'd0, got}, {32'd0, 32'hCAFE_F00D});
    check("b2b_miso2", {32'd0, got2}, {32'd0, 32'h1357_9BDF});
    check("b2b_underrun", 64'(ur_cnt - u0), 64'd0);

    // Abort after 13 bits, then a clean frame.
    r0 = rx_cnt; u0 = ur_cnt; a0 = ab_cnt;
    cs_n = 1'b0;
    shift_bits(32'hFFFF_FFFF, 13, 1'b1, got);
    tick(8);
    check("abort_pulses", 64'(ab_cnt - a0), 64'd1);
    check("abort_no_rx", 64'(rx_cnt - r0), 64'd0);
    check("abort_underrun", 64'(ur_cnt - u0), 64'd1);
    check("abort_miso_oe_off", {63'd0, miso_oe}, 64'd0);
    push_tx(32'h55AA_33CC);
    frame(32'h0F0F_1234, got);
    check("after_abort_rx", {32'd0, rx_data}, {32'd0, 32'h0F0F_1234});
    check("after_abort_pulses", 64'(rx_cnt - r0), 64'd1);
    check("after_abort_miso", {32'd0, got}, {32'd0, 32'h55AA_33CC});

    // Reset in the middle of a frame.
    push_tx(32'h1111_2222);
    cs_n = 1'b0;
    shift_bits(32'hF0F0_F0F0, 20, 1'b0, got);
    rst = 1'b1;
    #1;
    check("midreset_outputs",
          {26'd0, miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_abort},
          {26'd0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    cs_n = 1'b1; sclk = 1'b0;
    tick(4);
    r0 = rx_cnt; u0 = ur_cnt; a0 = ab_cnt;
    rst = 1'b0;
    tick(6);
    check("midreset_idle", {62'd0, miso_oe, tx_ready}, {62'd0, 1'b0, 1'b1});
    frame(32'h8000_0001, got);
    check("midreset_rx", {32'd0, rx_data}, {32'd0, 32'h8000_0001});
    check("midreset_pulses", 64'(rx_cnt - r0), 64'd1);
    check("midreset_miso", {32'd0, got}, {32'd0, 32'h0000_0000});
    check("midreset_underrun", 64'(ur_cnt - u0), 64'd1);
    check("midreset_abort", 64'(ab_cnt - a0), 64'd0);

    // SCLK noise with cs_n high must be ignored.
    r0 = rx_cnt; a0 = ab_cnt;
    for (int i = 0; i < 12; i++) begin
      mosi = i[0];
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      tick(4);
    end
    mosi = 1'b0;
    check("noise_miso_oe", {63'd0, miso_oe}, 64'd0);
    check("noise_no_rx", 64'(rx_cnt - r0), 64'd0);
    check("noise_no_abort", 64'(ab_cnt - a0), 64'd0);
    push_tx(32'h0F0F_0F0F);
    frame(32'hC3C3_A5A5, got);
    check("noise_next_rx", {32'd0, rx_data}, {32'd0, 32'hC3C3_A5A5});
    check("noise_next_miso", {32'd0, got}, {32'd0, 32'h0F0F_0F0F});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
